key_filter: RTL and testbench

KEY_FILTER -- requirements
Module: key_filter

---
 rtl/key_filter_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/key_filter.sv | 135 +++++++++++++
 tb/tb_key_filter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// Shared constants and FSM state encoding for the push-button debouncer.
// Default windows assume a 50 MHz clk (20 ms debounce, 1 s long press).
package key_filter_pkg;

   localparam int CNT_W  = 20;
   localparam int LONG_W = 26;

   localparam logic [CNT_W-1:0]  CNT_MAX_DEF  = 20'd999_999;
   localparam logic [LONG_W-1:0] LONG_MAX_DEF = 26'd49_999_999;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      FILTER_DOWN = 2'd1,
      DOWN        = 2'd2,
      FILTER_UP   = 2'd3
   } kf_state_e;

   // True while the key is considered held (confirmed press, possibly releasing).
   function automatic logic in_press(input kf_state_e s);
      return (s == DOWN) || (s == FILTER_UP);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser; resets to 1 so an idle (released) key
// looks released straight out of reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: press/release pulses CNT_MAX+4 cycles after a clean edge.
// Optional long-press pulse when KEY_LONG_PRESS_EN is defined; otherwise key_long is 0.
module key_filter
   import key_filter_pkg::*;
#(
   parameter logic [CNT_W-1:0]  CNT_MAX  = CNT_MAX_DEF,
   parameter logic [LONG_W-1:0] LONG_MAX = LONG_MAX_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_flag,
   output logic key_press,
   output logic key_state,
   output logic key_long
);

   logic             key_sync;
   logic             key_prev_q;
   logic             fall;
   logic             rise;
   kf_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             flag_q;
   logic             press_q;
   logic             level_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (key_in),
      .q_o (key_sync)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) key_prev_q <= 1'b1;
      else      key_prev_q <= key_sync;
   end

   assign fall  = key_prev_q & ~key_sync;
   assign rise  = ~key_prev_q & key_sync;
   assign cnt_d = cnt_q + CNT_W'(1);

   // Bounce edges are tested before the counter limit so a late edge wins.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         press_q <= 1'b0;
         level_q <= 1'b1;
      end else begin
         flag_q  <= 1'b0;
         press_q <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (fall) state_q <= FILTER_DOWN;
            end
            FILTER_DOWN: begin
               if (rise) begin
                  state_q <= IDLE;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= DOWN;
                  flag_q  <= 1'b1;
                  press_q <= 1'b1;
                  level_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            DOWN: begin
               cnt_q <= '0;
               if (rise) state_q <= FILTER_UP;
            end
            FILTER_UP: begin
               if (fall) begin
                  state_q <= DOWN;
               end else if (cnt_q == CNT_MAX) begin
                  state_q <= IDLE;
                  flag_q  <= 1'b1;
                  level_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign key_flag  = flag_q;
   assign key_press = press_q;
   assign key_state = level_q;

`ifdef KEY_LONG_PRESS_EN
   logic [LONG_W-1:0] long_cnt_q;
   logic [LONG_W-1:0] long_cnt_d;
   logic              long_done_q;
   logic              long_q;

   assign long_cnt_d = long_cnt_q + LONG_W'(1);

   // Counter parks at LONG_MAX; done flag limits the pulse to one per press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         long_cnt_q  <= '0;
         long_done_q <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (!in_press(state_q)) begin
            long_cnt_q  <= '0;
            long_done_q <= 1'b0;
         end else if (long_cnt_q == LONG_MAX) begin
            if (!long_done_q) begin
               long_q      <= 1'b1;
               long_done_q <= 1'b1;
            end
         end else begin
            long_cnt_q <= long_cnt_d;
         end
      end
   end

   assign key_long = long_q;
`else
   assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with CNT_MAX=4 (edge->flag = 8 cycles), LONG_MAX=20.
module tb_key_filter;

   logic clk    = 1'b0;
   logic rst    = 1'b1;
   logic key_in = 1'b1;
   logic key_flag, key_press, key_state, key_long;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   int n_flag = 0, n_press = 0, n_long = 0;
   int t_flag = 0, t_press = 0, t_long = 0;

   key_filter #(
      .CNT_MAX  (20'd4),
      .LONG_MAX (26'd20)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_in    (key_in),
      .key_flag  (key_flag),
      .key_press (key_press),
      .key_state (key_state),
      .key_long  (key_long)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   // Pulse monitor: counts and time-stamps pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (key_flag === 1'b1)  begin n_flag  = n_flag + 1;  t_flag  = cyc; end
      if (key_press === 1'b1) begin n_press = n_press + 1; t_press = cyc; end
      if (key_long === 1'b1)  begin n_long  = n_long + 1;  t_long  = cyc; end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2 rst = 1'b0;
      #3;
      checks++; if (key_flag !== 1'b0)  begin errors++; $display("FAIL reset_flag: got %b expected 0", key_flag); end
      checks++; if (key_press !== 1'b0) begin errors++; $display("FAIL reset_press: got %b expected 0", key_press); end
      checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL reset_state: got %b expected 1", key_state); end
      checks++; if (key_long !== 1'b0)  begin errors++; $display("FAIL reset_long: got %b expected 0", key_long); end
      tick(3);
      rst = 1'b1;
      tick(6);
      checks++; if (n_flag !== 0) begin errors++; $display("FAIL reset_idle_flags: got %0d expected 0", n_flag); end
      checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL reset_idle_state: got %b expected 1", key_state); end
   endtask

   task automatic test_clean_press;
      int c, f0, p0;
      f0 = n_flag; p0 = n_press;
      key_in = 1'b0; c = cyc;
      for (int i = 1; i <= 30; i++) begin
         tick(1);
         if (i == 7) begin
            checks++; if (key_flag !== 1'b0 || key_state !== 1'b1) begin errors++; $display("FAIL press_early: got flag=%b state=%b expected flag=0 state=1", key_flag, key_state); end
         end
         if (i == 8) begin
            checks++; if (key_flag !== 1'b1 || key_press !== 1'b1) begin errors++; $display("FAIL press_pulse: got flag=%b press=%b expected 1 1", key_flag, key_press); end
            checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL press_state: got %b expected 0", key_state); end
         end
      end
      checks++; if (n_flag - f0 !== 1)  begin errors++; $display("FAIL press_flag_count: got %0d expected 1", n_flag - f0); end
      checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL press_press_count: got %0d expected 1", n_press - p0); end
      checks++; if (t_flag - c !== 8)   begin errors++; $display("FAIL press_latency: got %0d expected 8", t_flag - c); end
   endtask

   task automatic test_release;
      int c, f0, p0;
      f0 = n_flag; p0 = n_press;
      key_in = 1'b1; c = cyc;
      for (int i = 1; i <= 20; i++) begin
         tick(1);
         if (i == 7) begin
            checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL release_early: got state=%b expected 0", key_state); end
         end
         if (i == 8) begin
            checks++; if (key_flag !== 1'b1 || key_press !== 1'b0 || key_state !== 1'b1) begin errors++; $display("FAIL release_pulse: got flag=%b press=%b state=%b expected 1 0 1", key_flag, key_press, key_state); end
         end
      end
      checks++; if (n_flag - f0 !== 1)  begin errors++; $display("FAIL release_flag_count: got %0d expected 1", n_flag - f0); end
      checks++; if (n_press - p0 !== 0) begin errors++; $display("FAIL release_press_count: got %0d expected 0", n_press - p0); end
      checks++; if (t_flag - c !== 8)   begin errors++; $display("FAIL release_latency: got %0d expected 8", t_flag - c); end
   endtask

   task automatic test_bounce_press;
      int c, f0, p0;
      f0 = n_flag; p0 = n_press;
      for (int k = 0; k < 4; k++) begin
         key_in = 1'(k % 2);
         tick(2);
      end
      key_in = 1'b0; c = cyc;
      tick(20);
      checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL bounce_press_count: got %0d expected 1", n_press - p0); end
      checks++; if (n_flag - f0 !== 1)  begin errors++; $display("FAIL bounce_flag_count: got %0d expected 1", n_flag - f0); end
      checks++; if (t_press - c !== 8)  begin errors++; $display("FAIL bounce_latency: got %0d expected 8", t_press - c); end
      checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL bounce_state: got %b expected 0", key_state); end
   endtask

   task automatic test_glitch;
      int f0;
      f0 = n_flag;
      key_in = 1'b0; tick(3);
      key_in = 1'b1; tick(15);
      checks++; if (n_flag - f0 !== 0)  begin errors++; $display("FAIL glitch_flag_count: got %0d expected 0", n_flag - f0); end
      checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL glitch_state: got %b expected 1", key_state); end
   endtask

   task automatic test_boundary;
      int c, f0, p0;
      // Low for CNT_MAX+1 cycles: the rise lands with counter == CNT_MAX and must win.
      f0 = n_flag;
      key_in = 1'b0; tick(5);
      key_in = 1'b1; tick(15);
      checks++; if (n_flag - f0 !== 0) begin errors++; $display("FAIL edge_priority_flag_count: got %0d expected 0", n_flag - f0); end
      // One cycle longer is accepted as a press, then released.
      f0 = n_flag; p0 = n_press;
      key_in = 1'b0; c = cyc; tick(6);
      key_in = 1'b1; tick(20);
      checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL min_press_count: got %0d expected 1", n_press - p0); end
      checks++; if (n_flag - f0 !== 2)  begin errors++; $display("FAIL min_flag_count: got %0d expected 2", n_flag - f0); end
      checks++; if (t_press - c !== 8)  begin errors++; $display("FAIL min_press_time: got %0d expected 8", t_press - c); end
      checks++; if (t_flag - c !== 14)  begin errors++; $display("FAIL min_release_time: got %0d expected 14", t_flag - c); end
      checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL min_state: got %b expected 1", key_state); end
   endtask

   task automatic test_long_press;
      int c, l0, p0, exp_long;
`ifdef KEY_LONG_PRESS_EN
      exp_long = 1;
`else
      exp_long = 0;
`endif
      l0 = n_long; p0 = n_press;
      key_in = 1'b0; c = cyc;
      tick(40);
      checks++; if (n_long - l0 !== exp_long) begin errors++; $display("FAIL long_count: got %0d expected %0d", n_long - l0, exp_long); end
      checks++; if (n_press - p0 !== 1) begin errors++; $display("FAIL long_press_count: got %0d expected 1", n_press - p0); end
      checks++; if (t_press - c !== 8)  begin errors++; $display("FAIL long_press_time: got %0d expected 8", t_press - c); end
`ifdef KEY_LONG_PRESS_EN
      checks++; if (t_long - c !== 29)  begin errors++; $display("FAIL long_time: got %0d expected 29", t_long - c); end
`endif
      key_in = 1'b1; tick(20);
      checks++; if (n_long - l0 !== exp_long) begin errors++; $display("FAIL long_after_release: got %0d expected %0d", n_long - l0, exp_long); end
   endtask

   task automatic test_reset_mid_filter;
      int c, f0, p0;
      key_in = 1'b0; tick(5);
      rst = 1'b0; #1;
      checks++; if (key_flag !== 1'b0 || key_press !== 1'b0 || key_state !== 1'b1 || key_long !== 1'b0) begin errors++; $display("FAIL midfilter_reset_outputs: got %b%b%b%b expected 0010", key_flag, key_press, key_state, key_long); end
      tick(3);
      f0 = n_flag; p0 = n_press;
      rst = 1'b1; c = cyc;
      tick(7);
      checks++; if (n_flag - f0 !== 0) begin errors++; $display("FAIL midfilter_no_early_pulse: got %0d expected 0", n_flag - f0); end
      tick(1);
      checks++; if (key_flag !== 1'b1 || key_press !== 1'b1) begin errors++; $display("FAIL midfilter_new_press: got flag=%b press=%b expected 1 1", key_flag, key_press); end
      tick(12);
      checks++; if (n_press - p0 !== 1 || t_press - c !== 8) begin errors++; $display("FAIL midfilter_press_timing: got count=%0d time=%0d expected 1 8", n_press - p0, t_press - c); end
   endtask

   task automatic test_reset_mid_press;
      int f0;
      // Key is still held and confirmed from the previous scenario.
      checks++; if (key_state !== 1'b0) begin errors++; $display("FAIL midpress_precondition: got %b expected 0", key_state); end
      rst = 1'b0; #1;
      checks++; if (key_state !== 1'b1) begin errors++; $display("FAIL midpress_async_state: got %b expected 1", key_state); end
      key_in = 1'b1;
      tick(3);
      f0 = n_flag;
      rst = 1'b1;
      tick(20);
      checks++; if (n_flag - f0 !== 0 || key_state !== 1'b1) begin errors++; $display("FAIL midpress_after_release: got flags=%0d state=%b expected 0 1", n_flag - f0, key_state); end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_release();
      test_bounce_press();
      test_release();
      test_glitch();
      test_boundary();
      test_long_press();
      test_reset_mid_filter();
      test_reset_mid_press();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
